// File: rtl/soc2_uart_pkg.sv
// soc2_uart_pkg: shared definitions for the SoC2 UART receive path.
//   - rx_state_e      : receiver FSM state encoding
//   - DATA_BITS       : payload bits per frame
//   - DEFAULT_CLKS_PER_BIT : 50 MHz system clock / 115200 baud
//   - even_parity()   : parity bit value that makes the total count of ones even
package soc2_uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  // Even parity: the parity bit equals the XOR of the data bits.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so a line in reset looks idle (no false start bit).
// Ports:
//   clk    in  sampling clock
//   resetn in  asynchronous active-low reset
//   d      in  asynchronous input
//   q      out synchronized output (2 cycles of latency)
module uart_rx_sync (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage metastability filter, both stages preset to idle-high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8 data bits, LSB first, 1 stop bit.
// Optional even parity bit enabled by defining SOC2_UART_RX_PARITY_EN
// (otherwise 8N1 and rx_parity_err is tied low).
// Ports:
//   clk           in  system clock, all state on rising edge
//   resetn        in  asynchronous active-low reset
//   rxd           in  asynchronous serial line, idle high
//   rx_data       out last correctly framed byte
//   rx_data_fresh out one-cycle pulse, rx_data just updated
//   rx_frame_err  out one-cycle pulse, stop bit sampled low
//   rx_parity_err out one-cycle pulse, parity mismatch
//   rx_busy       out high whenever the FSM is not idle
// Parameter CLKS_PER_BIT: clk cycles per serial bit, legal 8..65535.
module uart_rx
  import soc2_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_fresh,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  // Half-bit load centres sampling in the start bit; full-bit load steps
  // from one bit centre to the next.
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [BW-1:0] BIT_ZERO  = BW'(0);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic                 rxd_s;
  rx_state_e            state_r, state_n;
  logic [CW-1:0]        cnt_r, cnt_n;
  logic [BW-1:0]        bit_cnt_r, bit_cnt_n;
  logic [DATA_BITS-1:0] shift_r, shift_n;
  logic [DATA_BITS-1:0] rx_data_r, rx_data_n;
  logic                 fresh_r, fresh_n;
  logic                 ferr_r, ferr_n;
  logic                 busy_r;
  logic                 cnt_done_s;
  logic                 par_bad_s;
`ifdef SOC2_UART_RX_PARITY_EN
  logic                 par_err_r, par_err_n;
  logic                 perr_r, perr_n;
`endif

  uart_rx_sync u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (rxd),
    .q      (rxd_s)
  );

  assign cnt_done_s = (cnt_r == CNT_ZERO);

`ifdef SOC2_UART_RX_PARITY_EN
  assign par_bad_s = par_err_r;
`else
  assign par_bad_s = 1'b0;
`endif

  // Next-state, counters, shift register and output pulse decode.
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    bit_cnt_n = bit_cnt_r;
    shift_n   = shift_r;
    rx_data_n = rx_data_r;
    fresh_n   = 1'b0;
    ferr_n    = 1'b0;
`ifdef SOC2_UART_RX_PARITY_EN
    par_err_n = par_err_r;
    perr_n    = 1'b0;
`endif

    case (state_r)
      ST_IDLE: begin
        if (!rxd_s) begin
          state_n   = ST_START;
          cnt_n     = HALF_LOAD;
          bit_cnt_n = BIT_ZERO;
`ifdef SOC2_UART_RX_PARITY_EN
          par_err_n = 1'b0;
`endif
        end else begin
          state_n = ST_IDLE;
        end
      end

      ST_START: begin
        if (cnt_done_s) begin
          // A start bit that is high again at its centre was a glitch.
          if (rxd_s) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_DATA;
            cnt_n   = FULL_LOAD;
          end
        end else begin
          cnt_n = cnt_r - CNT_ONE;
        end
      end

      ST_DATA: begin
        if (cnt_done_s) begin
          shift_n = {rxd_s, shift_r[DATA_BITS-1:1]};
          cnt_n   = FULL_LOAD;
          if (bit_cnt_r == LAST_BIT) begin
`ifdef SOC2_UART_RX_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
          end else begin
            bit_cnt_n = bit_cnt_r + BIT_ONE;
          end
        end else begin
          cnt_n = cnt_r - CNT_ONE;
        end
      end

      ST_PARITY: begin
`ifdef SOC2_UART_RX_PARITY_EN
        if (cnt_done_s) begin
          par_err_n = (rxd_s != even_parity(shift_r));
          state_n   = ST_STOP;
          cnt_n     = FULL_LOAD;
        end else begin
          cnt_n = cnt_r - CNT_ONE;
        end
`else
        // Unreachable in 8N1 builds; recover to idle.
        state_n = ST_IDLE;
`endif
      end

      ST_STOP: begin
        if (cnt_done_s) begin
`ifdef SOC2_UART_RX_PARITY_EN
          perr_n = par_err_r;
`endif
          if (rxd_s) begin
            state_n = ST_IDLE;
            if (!par_bad_s) begin
              rx_data_n = shift_r;
              fresh_n   = 1'b1;
            end else begin
              fresh_n = 1'b0;
            end
          end else begin
            // Low stop bit: report once, then wait out a held-low line.
            state_n = ST_BREAK;
            ferr_n  = 1'b1;
          end
        end else begin
          cnt_n = cnt_r - CNT_ONE;
        end
      end

      ST_BREAK: begin
        if (rxd_s) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_BREAK;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered output pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      bit_cnt_r <= BIT_ZERO;
      shift_r   <= {DATA_BITS{1'b0}};
      rx_data_r <= {DATA_BITS{1'b0}};
      fresh_r   <= 1'b0;
      ferr_r    <= 1'b0;
      busy_r    <= 1'b0;
`ifdef SOC2_UART_RX_PARITY_EN
      par_err_r <= 1'b0;
      perr_r    <= 1'b0;
`endif
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      bit_cnt_r <= bit_cnt_n;
      shift_r   <= shift_n;
      rx_data_r <= rx_data_n;
      fresh_r   <= fresh_n;
      ferr_r    <= ferr_n;
      // Registered copy of (state != IDLE), tracks state_r exactly.
      busy_r    <= (state_n != ST_IDLE);
`ifdef SOC2_UART_RX_PARITY_EN
      par_err_r <= par_err_n;
      perr_r    <= perr_n;
`endif
    end
  end

  assign rx_data       = rx_data_r;
  assign rx_data_fresh = fresh_r;
  assign rx_frame_err  = ferr_r;
  assign rx_busy       = busy_r;
`ifdef SOC2_UART_RX_PARITY_EN
  assign rx_parity_err = perr_r;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at CLKS_PER_BIT=16.
// Good frames push their byte to a scoreboard queue; a monitor pops and
// compares whenever rx_data_fresh pulses.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef SOC2_UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_data_fresh;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       rx_busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .rxd           (rxd),
    .rx_data       (rx_data),
    .rx_data_fresh (rx_data_fresh),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int fresh_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int unsigned last_fresh_cyc = 0;
  int unsigned prev_fresh_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;
  logic fresh_d = 1'b0, ferr_d = 1'b0, perr_d = 1'b0;

  // Scoreboard monitor and pulse-width watch, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_data_fresh === 1'b1) begin
      fresh_cnt++;
      prev_fresh_cyc = last_fresh_cyc;
      last_fresh_cyc = cyc;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL fresh_unexpected got=%0h expected=none", rx_data);
      end
      if (exp_q.size() > 0) begin
        exp_byte = exp_q.pop_front();
        checks++;
        assert (rx_data === exp_byte) else begin
          errors++;
          $error("FAIL sb_data got=%0h expected=%0h", rx_data, exp_byte);
        end
      end
    end
    if (rx_frame_err === 1'b1) ferr_cnt++;
    if (rx_parity_err === 1'b1) perr_cnt++;
    if ((rx_data_fresh | rx_frame_err | rx_parity_err) === 1'b1) begin
      checks++;
      assert (!((rx_data_fresh & fresh_d) | (rx_frame_err & ferr_d) |
                (rx_parity_err & perr_d))) else begin
        errors++;
        $error("FAIL pulse_width got=%b%b%b prev=%b%b%b expected=single-cycle",
               rx_data_fresh, rx_frame_err, rx_parity_err, fresh_d, ferr_d, perr_d);
      end
    end
    fresh_d = rx_data_fresh;
    ferr_d  = rx_frame_err;
    perr_d  = rx_parity_err;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    wait_cycles(CPB);
  endtask

  // Full frame: start, 8 data LSB first, optional parity, stop.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef SOC2_UART_RX_PARITY_EN
    send_bit(par_bit);
`else
    if (par_bit === 1'bx) $display("note: parity bit unused");
`endif
    send_bit(stop_bit);
  endtask

  int f0, e0, p0;
  int unsigned start_cyc, lat;
  logic [7:0] tmp;

  initial begin
    rxd    = 1'b1;
    resetn = 1'b0;
    wait_cycles(3);

    // Reset state
    chk("rst_data",  {24'd0, rx_data}, 32'h00);
    chk("rst_fresh", {31'd0, rx_data_fresh}, 32'd0);
    chk("rst_ferr",  {31'd0, rx_frame_err}, 32'd0);
    chk("rst_perr",  {31'd0, rx_parity_err}, 32'd0);
    chk("rst_busy",  {31'd0, rx_busy}, 32'd0);
    resetn = 1'b1;
    wait_cycles(2 * CPB);

    // Single frame 0x55; fresh about 9.5 bit times after the falling edge
    // plus synchronizer and output register latency.
    f0 = fresh_cnt;
    tmp = 8'h55;
    exp_q.push_back(tmp);
    start_cyc = cyc;
    send_frame(tmp, 1'b1, ^tmp);
    wait_cycles(2 * CPB);
    chk("f55_count", fresh_cnt - f0, 32'd1);
    chk("f55_data", {24'd0, rx_data}, 32'h55);
    lat = last_fresh_cyc - start_cyc;
    chk("f55_latency_window",
        {31'd0, (lat >= (FRAME_BITS - 1) * CPB + CPB / 2) && (lat <= (FRAME_BITS - 1) * CPB + CPB / 2 + 8)},
        32'd1);

    // Back-to-back 0xA3, 0x0F
    f0 = fresh_cnt;
    tmp = 8'hA3;
    exp_q.push_back(tmp);
    send_frame(tmp, 1'b1, ^tmp);
    tmp = 8'h0F;
    exp_q.push_back(tmp);
    send_frame(tmp, 1'b1, ^tmp);
    wait_cycles(2 * CPB);
    chk("b2b_count", fresh_cnt - f0, 32'd2);
    chk("b2b_gap", last_fresh_cyc - prev_fresh_cyc, FRAME_BITS * CPB);
    chk("b2b_data", {24'd0, rx_data}, 32'h0F);

    // Start-bit glitch of 4 cycles is rejected
    f0 = fresh_cnt;
    e0 = ferr_cnt;
    rxd = 1'b0;
    wait_cycles(4);
    rxd = 1'b1;
    wait_cycles(3 * CPB);
    chk("glitch_fresh", fresh_cnt - f0, 32'd0);
    chk("glitch_ferr", ferr_cnt - e0, 32'd0);
    chk("glitch_data", {24'd0, rx_data}, 32'h0F);
    chk("glitch_busy", {31'd0, rx_busy}, 32'd0);

    // 0x81 with low stop bit, line held low for 40 bit times
    f0 = fresh_cnt;
    e0 = ferr_cnt;
    tmp = 8'h81;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(tmp[i]);
`ifdef SOC2_UART_RX_PARITY_EN
    send_bit(^tmp);
`endif
    rxd = 1'b0;
    wait_cycles(40 * CPB);
    chk("brk_busy_low", {31'd0, rx_busy}, 32'd1);
    chk("brk_ferr", ferr_cnt - e0, 32'd1);
    chk("brk_fresh", fresh_cnt - f0, 32'd0);
    chk("brk_data", {24'd0, rx_data}, 32'h0F);
    rxd = 1'b1;
    wait_cycles(6);
    chk("brk_busy_release", {31'd0, rx_busy}, 32'd0);
    wait_cycles(2 * CPB);
    chk("brk_ferr_once", ferr_cnt - e0, 32'd1);

    // Reset during bit 4 of 0xFF, then a clean 0x3C
    f0 = fresh_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rxd = 1'b1;
    wait_cycles(CPB / 2);
    resetn = 1'b0;
    wait_cycles(2);
    chk("midrst_data", {24'd0, rx_data}, 32'h00);
    chk("midrst_busy", {31'd0, rx_busy}, 32'd0);
    resetn = 1'b1;
    wait_cycles(CPB / 2 + 5 * CPB);
    chk("midrst_no_fresh", fresh_cnt - f0, 32'd0);
    tmp = 8'h3C;
    exp_q.push_back(tmp);
    send_frame(tmp, 1'b1, ^tmp);
    wait_cycles(2 * CPB);
    chk("post_rst_count", fresh_cnt - f0, 32'd1);
    chk("post_rst_data", {24'd0, rx_data}, 32'h3C);

`ifdef SOC2_UART_RX_PARITY_EN
    // 0x07 with wrong parity, then with correct parity
    f0 = fresh_cnt;
    p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    wait_cycles(2 * CPB);
    chk("par_bad_perr", perr_cnt - p0, 32'd1);
    chk("par_bad_fresh", fresh_cnt - f0, 32'd0);
    chk("par_bad_data", {24'd0, rx_data}, 32'h3C);
    tmp = 8'h07;
    exp_q.push_back(tmp);
    send_frame(tmp, 1'b1, 1'b1);
    wait_cycles(2 * CPB);
    chk("par_ok_fresh", fresh_cnt - f0, 32'd1);
    chk("par_ok_data", {24'd0, rx_data}, 32'h07);
`else
    p0 = 0;
    chk("no_parity_err", perr_cnt - p0, 32'd0);
`endif

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
